// File: rtl/fp_exp_align.sv
// Exponent-compare and operand-routing stage ahead of the FPU mantissa alignment shifter.
// Two-stage valid/ready pipeline: unpack/classify, then order by magnitude and clamp the exponent difference.
module fp_exp_align #(
  parameter int unsigned CLAMP = 31
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [23:0] o_mant_big,
  output logic [23:0] o_mant_small,
  output logic [7:0]  o_exp_diff,
  output logic [7:0]  o_exp_big,
  output logic        o_sign_big,
  output logic        o_sign_small,
  output logic        o_swap,
  output logic        o_is_nan,
  output logic        o_is_inf,
  output logic        o_is_zero
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned DIFF_W = 9;
  localparam logic signed [9:0] CLAMP_POS = 10'(CLAMP);
  localparam logic signed [9:0] CLAMP_NEG = -CLAMP_POS;

  typedef enum logic [2:0] {
    CLS_ZERO, CLS_DENORM, CLS_NORMAL, CLS_INF, CLS_NAN
  } cls_e;

  function automatic cls_e classify(input logic [7:0] e, input logic [22:0] f);
    if (e == 8'd0)        return (f == 23'd0) ? CLS_ZERO : CLS_DENORM;
    else if (e == 8'hFF)  return (f == 23'd0) ? CLS_INF : CLS_NAN;
    else                  return CLS_NORMAL;
  endfunction

  // Stage 1 state
  logic              r_s1_valid;
  logic              r_s1_sign_a, r_s1_sign_b;
  logic [EXP_W-1:0]  r_s1_exp_a, r_s1_exp_b;
  logic [MANT_W-1:0] r_s1_mant_a, r_s1_mant_b;
  cls_e              r_s1_cls_a, r_s1_cls_b;
  logic [DIFF_W-1:0] r_s1_diff;

  // Stage 2 state (drives the outputs)
  logic              r_s2_valid;
  logic [MANT_W-1:0] r_mant_big, r_mant_small;
  logic [EXP_W-1:0]  r_exp_diff, r_exp_big;
  logic              r_sign_big, r_sign_small, r_swap;
  logic              r_is_nan, r_is_inf, r_is_zero;

  logic              w_s1_load, w_s2_load;
  logic [EXP_W-1:0]  w_exp_a, w_exp_b;
  logic [MANT_W-1:0] w_mant_a, w_mant_b;
  logic [DIFF_W-1:0] w_diff;
  logic signed [9:0] w_diff_ext;
  logic [EXP_W-1:0]  w_exp_diff;
  logic              w_swap, w_nan, w_inf, w_zero;

  // A stage loads when empty or when its contents move forward this cycle
  always_comb begin
    w_s2_load  = !r_s2_valid || i_out_ready;
    w_s1_load  = !r_s1_valid || w_s2_load;
    o_in_ready = w_s1_load;
  end

  // Unpack: denormals use effective exponent 1 with a zero hidden bit
  always_comb begin
    w_exp_a  = (i_a[30:23] == 8'd0) ? 8'd1 : i_a[30:23];
    w_exp_b  = (i_b[30:23] == 8'd0) ? 8'd1 : i_b[30:23];
    w_mant_a = {(i_a[30:23] != 8'd0), i_a[22:0]};
    w_mant_b = {(i_b[30:23] != 8'd0), i_b[22:0]};
    w_diff   = DIFF_W'(w_exp_a) - DIFF_W'(w_exp_b);
  end

  // Magnitude ordering, saturated signed difference and special-case flags
  always_comb begin
    w_swap     = (r_s1_exp_b > r_s1_exp_a) ||
                 ((r_s1_exp_b == r_s1_exp_a) && (r_s1_mant_b > r_s1_mant_a));
    w_diff_ext = {r_s1_diff[DIFF_W-1], r_s1_diff};
    w_exp_diff = r_s1_diff[EXP_W-1:0];
    if (w_diff_ext > CLAMP_POS)      w_exp_diff = CLAMP_POS[EXP_W-1:0];
    else if (w_diff_ext < CLAMP_NEG) w_exp_diff = CLAMP_NEG[EXP_W-1:0];
    w_nan  = (r_s1_cls_a == CLS_NAN) || (r_s1_cls_b == CLS_NAN) ||
             ((r_s1_cls_a == CLS_INF) && (r_s1_cls_b == CLS_INF) && (r_s1_sign_a != r_s1_sign_b));
    w_inf  = !w_nan && ((r_s1_cls_a == CLS_INF) || (r_s1_cls_b == CLS_INF));
    w_zero = (r_s1_cls_a == CLS_ZERO) && (r_s1_cls_b == CLS_ZERO);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_sign_a  <= 1'b0;
      r_s1_sign_b  <= 1'b0;
      r_s1_exp_a   <= '0;
      r_s1_exp_b   <= '0;
      r_s1_mant_a  <= '0;
      r_s1_mant_b  <= '0;
      r_s1_cls_a   <= CLS_ZERO;
      r_s1_cls_b   <= CLS_ZERO;
      r_s1_diff    <= '0;
      r_s2_valid   <= 1'b0;
      r_mant_big   <= '0;
      r_mant_small <= '0;
      r_exp_diff   <= '0;
      r_exp_big    <= '0;
      r_sign_big   <= 1'b0;
      r_sign_small <= 1'b0;
      r_swap       <= 1'b0;
      r_is_nan     <= 1'b0;
      r_is_inf     <= 1'b0;
      r_is_zero    <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= i_in_valid;
        if (i_in_valid) begin
          r_s1_sign_a <= i_a[31];
          r_s1_sign_b <= i_b[31];
          r_s1_exp_a  <= w_exp_a;
          r_s1_exp_b  <= w_exp_b;
          r_s1_mant_a <= w_mant_a;
          r_s1_mant_b <= w_mant_b;
          r_s1_cls_a  <= classify(i_a[30:23], i_a[22:0]);
          r_s1_cls_b  <= classify(i_b[30:23], i_b[22:0]);
          r_s1_diff   <= w_diff;
        end
      end
      if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_swap       <= w_swap;
          r_mant_big   <= w_swap ? r_s1_mant_b : r_s1_mant_a;
          r_mant_small <= w_swap ? r_s1_mant_a : r_s1_mant_b;
          r_exp_big    <= w_swap ? r_s1_exp_b  : r_s1_exp_a;
          r_sign_big   <= w_swap ? r_s1_sign_b : r_s1_sign_a;
          r_sign_small <= w_swap ? r_s1_sign_a : r_s1_sign_b;
          r_exp_diff   <= w_exp_diff;
          r_is_nan     <= w_nan;
          r_is_inf     <= w_inf;
          r_is_zero    <= w_zero;
        end
      end
    end
  end

  always_comb begin
    o_out_valid  = r_s2_valid;
    o_mant_big   = r_mant_big;
    o_mant_small = r_mant_small;
    o_exp_diff   = r_exp_diff;
    o_exp_big    = r_exp_big;
    o_sign_big   = r_sign_big;
    o_sign_small = r_sign_small;
    o_swap       = r_swap;
    o_is_nan     = r_is_nan;
    o_is_inf     = r_is_inf;
    o_is_zero    = r_is_zero;
  end

endmodule
